seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Output-side counterpart to the board input debouncer. It takes a 32-bit value from the CPU datapath or debug mux and time-multiplexes it as eight hex digits onto the board's common-anode 7-segment display. Board outputs are active-low. New data is double-buffered and swapped only at frame boundaries, so the display never tears. A ghost-blanking interval at the start of each digit slot suppresses cross-digit shadowing.

## Interface
- `SCAN_DIV`, default 100000: cycles per digit slot (1 ms at 100 MHz); must be ≥ `GHOST`+1.
- `GHOST`, default 1000: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `clk` input 1: single system clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `data_in` input 32: value to display; digit i shows `data_in[4i+3:4i]`.
- `point_in` input 8: decimal point per digit, 1 = lit.
- `blank_in` input 8: per-digit blank, 1 = anode kept off during that digit's slot.
- `load` input 1: one-cycle strobe; captures `data_in`, `point_in` and `blank_in` into the pending buffer.
- `an` output 8: anode enables, active-low, one-hot-low or all-high.
- `seg` output 8: `seg[6:0]` = gfedcba, active-low; `seg[7]` = dp, active-low.
- `frame_tick` output 1: one-cycle pulse when the digit index wraps 7→0.

## Operation
- Registers:
  - `cnt` (0..`SCAN_DIV`-1)
  - `idx` (3 bits)
  - display buffer: `disp_data`/`disp_pt`/`disp_blank`
  - pending buffer: `pend_*` plus `pend_valid`
- Reset values:
  - `an`=8'hFF, `seg`=8'hFF, `frame_tick`=0
  - `cnt`=0, `idx`=0
  - all buffers 0, `pend_valid`=0
- Per-slot FSM, derived from `cnt`:
  - GHOST phase while `cnt`<`GHOST`.
  - DRIVE phase while `GHOST`≤`cnt`≤`SCAN_DIV`-1.
- At `cnt`=`SCAN_DIV`-1:
  - `cnt`←0 and `idx`←`idx`+1 (mod 8).
  - Otherwise `cnt`←`cnt`+1.
- Frame boundary is `cnt`=`SCAN_DIV`-1 with `idx`=7. On that cycle:
  - `frame_tick`←1.
  - If `pend_valid`, the display buffer ←pending buffer and `pend_valid`←0.
- `load` sets the pending buffer and `pend_valid`←1. Multiple loads within a frame: the last one wins.
- `load` coincident with a frame boundary:
  - The swap uses the pending contents from before that cycle.
  - The new value stays pending with `pend_valid`=1 and is shown from the following frame.
- Outputs during GHOST, or DRIVE with `disp_blank[idx]`=1: `an`←8'hFF, `seg`←8'hFF.
- Outputs during DRIVE otherwise:
  - `an`←~(1<<`idx`)
  - `seg[6:0]`←hex(`disp_data[4idx+3:4idx]`)
  - `seg[7]`←~`disp_pt[idx]`
- Hex table (`seg[6:0]`), digits 0-7: 40, 79, 24, 30, 19, 12, 02, 78.
- Hex table (`seg[6:0]`), digits 8-F: 00, 10, 08, 03, 46, 21, 06, 0E.
- Reset mid-frame: all state returns to reset values immediately; pending data is lost.

## Timing
- `an`, `seg` and `frame_tick` are registered.
- Outputs at edge t+1 are a function of (`cnt`, `idx`, buffers) at edge t.
- Slot length is exactly `SCAN_DIV` cycles; frame length is 8·`SCAN_DIV` cycles.
- Per slot, `an` shows exactly `GHOST` cycles of 8'hFF followed by `SCAN_DIV`-`GHOST` cycles of the driven pattern.
- After the first post-reset edge, `frame_tick` is high every 8·`SCAN_DIV` cycles, for one cycle, coincident with the last output cycle of digit 7's drive.
- Load-to-visible latency: from the next frame boundary, the first drive of digit 0 shows the new data.
  - Minimum latency is `GHOST`+2 cycles, when `load` is asserted the cycle before the boundary.
  - Maximum latency is 8·`SCAN_DIV`+`GHOST`+1 cycles.
- Never two anodes low in the same cycle; transitions between digits always pass through 8'hFF.

## Structure
- Package `seg7_pkg`:
  - 16-entry hex segment constants
  - `SEG_OFF`=8'hFF, `AN_OFF`=8'hFF
  - digit-count constant 8
- Sub-module `seg7_hex_decode`: combinational, 4-bit nibble in → 7-bit active-low segments out; instantiated once on the muxed nibble.
- Top holds the counter, the slot/frame logic, the double buffer and the output registers.

## Test plan
All scenarios use `SCAN_DIV`=8, `GHOST`=2.
- Reset then idle:
  - `an`=FF and `seg`=FF throughout reset.
  - After reset, each digit shows 2 cycles of FF then 6 cycles of `an`=FE..7F in turn with `seg`=C0 ("0", dp off).
  - `frame_tick` every 64 cycles.
- Load 32'h89ABCDEF with `point_in`=8'h01 mid-frame:
  - Current frame unchanged.
  - Next frame shows digit 0 `an`=FE with `seg`=0E (F, dp lit).
  - Digit 7 shows `seg`=80 (8, dp off).
- Load 32'h11111111, then load 32'h22222222 in the same frame: next frame shows all digits `seg`=A4 (2); 1 is never displayed.
- `load` exactly on the frame-boundary cycle: the following frame shows the old data; the frame after that shows the new data; `pend_valid` is 1 between them.
- `blank_in`=8'hF0 with data 32'h01234567: digits 4-7 keep `an`=FF during their slots; digits 0-3 show `seg`=F8, 82, 92, 99 (7, 6, 5, 4).
- Assert `rst` for 1 cycle mid-slot of digit 5 with a pending load: outputs go to FF asynchronously, scanning restarts at digit 0 with `cnt`=0, and the pending data is never shown.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low, bit order gfedcba.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Entry n is the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        PH_GHOST,
        PH_DRIVE
    } phase_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed 7-segment driver with a frame-synchronous
// double buffer and a per-slot ghost-blanking interval.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned GHOST    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  blank_in,
    input  logic        load,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int unsigned   CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic          slot_end;
    logic          frame_end;

    phase_t phase;
    phase_t phase_nxt;

    logic [31:0] disp_data;
    logic [7:0]  disp_pt;
    logic [7:0]  disp_blank;
    logic [31:0] pend_data;
    logic [7:0]  pend_pt;
    logic [7:0]  pend_blank;
    logic        pend_valid;

    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic [7:0] an_d;
    logic [7:0] seg_d;

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == 3'd7);
        cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (slot_end) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_GHOST;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Phase tracks the value cnt will hold next, so it always matches cnt.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            PH_GHOST: if (cnt_nxt >= CNT_GHOST) phase_nxt = PH_DRIVE;
            PH_DRIVE: if (slot_end)             phase_nxt = PH_GHOST;
            default:                            phase_nxt = PH_GHOST;
        endcase
    end

    // Swap reads the pending buffer before any same-cycle load overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data  <= '0;
            disp_pt    <= '0;
            disp_blank <= '0;
            pend_data  <= '0;
            pend_pt    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                disp_data  <= pend_data;
                disp_pt    <= pend_pt;
                disp_blank <= pend_blank;
            end
            if (load) begin
                pend_data  <= data_in;
                pend_pt    <= point_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble = disp_data[{idx, 2'b00} +: 4];
    end

    seg7_hex_decode u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (phase == PH_DRIVE && !disp_blank[idx]) begin
            an_d  = ~(8'h01 << idx);
            seg_d = {~disp_pt[idx], hex_seg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=8, GHOST=2.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int GH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  point_in;
    logic [7:0]  blank_in;
    logic        load;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV (SD),
        .GHOST    (GH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .point_in   (point_in),
        .blank_in   (blank_in),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       ft;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int          m_cnt, m_idx;
    logic [31:0] m_data, p_data;
    logic [7:0]  m_pt, m_blank, p_pt, p_blank;
    logic        p_valid;

    logic [7:0] seen_seg [8];
    bit         seen_lit [8];
    bit         seen_one;
    int         cyc = 0;
    int         last_ft = -1;
    int         ft_period = 0;

    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;  m_idx = 0;
        m_data = '0; m_pt = '0; m_blank = '0;
        p_data = '0; p_pt = '0; p_blank = '0;
        p_valid = 1'b0;
    endtask

    task automatic clear_seen();
        for (int d = 0; d < 8; d++) begin
            seen_seg[d] = 8'h00;
            seen_lit[d] = 1'b0;
        end
    endtask

    task automatic tick();
        exp_t e;
        bit   bnd;
        e.an  = 8'hFF;
        e.seg = 8'hFF;
        e.ft  = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_cnt >= GH && !m_blank[m_idx]) begin
                e.an  = ~(8'h01 << m_idx);
                e.seg = {~m_pt[m_idx], ref_hex(m_data[m_idx*4 +: 4])};
            end
            bnd  = (m_cnt == SD - 1) && (m_idx == 7);
            e.ft = bnd;
            if (bnd && p_valid) begin
                m_data = p_data; m_pt = p_pt; m_blank = p_blank;
            end
            if (load) begin
                p_data = data_in; p_pt = point_in; p_blank = blank_in;
                p_valid = 1'b1;
            end else if (bnd) begin
                p_valid = 1'b0;
            end
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        sbq.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sbq.pop_front();
        chk("an", an, e.an);
        chk("seg", seg, e.seg);
        chk("frame_tick", frame_tick, e.ft);

        for (int d = 0; d < 8; d++) begin
            if (an == ~(8'h01 << d)) begin
                seen_seg[d] = seg;
                seen_lit[d] = 1'b1;
            end
        end
        if (an != 8'hFF && seg == 8'hF9) seen_one = 1'b1;
        if (frame_tick) begin
            if (last_ft >= 0) ft_period = cyc - last_ft;
            last_ft = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic go_to(input int i, input int c);
        for (int k = 0; k < 200; k++) begin
            if (m_idx == i && m_cnt == c) return;
            tick();
        end
        chk("go_to_bound", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
        data_in  = d;
        point_in = p;
        blank_in = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        blank_in = '0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0;
        data_in = '0; point_in = '0; blank_in = '0;
        model_reset();
        clear_seen();
        seen_one = 1'b0;

        // Reset then idle
        #1;
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        run(3);
        rst = 1'b0;
        run(140);
        chk("ft_period", ft_period, 64);
        for (int d = 0; d < 8; d++) chk("idle_seg", seen_seg[d], 8'hC0);

        // Mid-frame load
        go_to(3, 4);
        do_load(32'h89ABCDEF, 8'h01, 8'h00);
        clear_seen();
        go_to(7, 7);
        tick();
        chk("cur_frame_d7", seen_seg[7], 8'hC0);
        clear_seen();
        run(64);
        chk("new_d0", seen_seg[0], 8'h0E);
        chk("new_d1", seen_seg[1], 8'h86);
        chk("new_d7", seen_seg[7], 8'h80);

        // Last load in a frame wins
        seen_one = 1'b0;
        go_to(1, 3);
        do_load(32'h11111111, 8'h00, 8'h00);
        go_to(4, 3);
        do_load(32'h22222222, 8'h00, 8'h00);
        go_to(7, 7);
        tick();
        clear_seen();
        run(64);
        chk("one_never_shown", seen_one, 0);
        for (int d = 0; d < 8; d++) chk("last_wins_seg", seen_seg[d], 8'hA4);

        // Load on the frame-boundary cycle
        go_to(7, 7);
        do_load(32'h33333333, 8'h00, 8'h00);
        chk("pend_after_bnd_load", dut.pend_valid, 1);
        clear_seen();
        run(32);
        chk("pend_mid_frame", dut.pend_valid, 1);
        run(32);
        chk("bnd_old_d0", seen_seg[0], 8'hA4);
        chk("bnd_old_d7", seen_seg[7], 8'hA4);
        chk("pend_cleared", dut.pend_valid, 0);
        clear_seen();
        run(64);
        chk("bnd_new_d0", seen_seg[0], 8'hB0);

        // Per-digit blanking
        do_load(32'h01234567, 8'h00, 8'hF0);
        go_to(7, 7);
        tick();
        clear_seen();
        run(64);
        for (int d = 4; d < 8; d++) chk("blank_lit", seen_lit[d], 0);
        chk("blank_d0", seen_seg[0], 8'hF8);
        chk("blank_d1", seen_seg[1], 8'h82);
        chk("blank_d2", seen_seg[2], 8'h92);
        chk("blank_d3", seen_seg[3], 8'h99);

        // Reset mid-slot of digit 5 with pending data
        do_load(32'h00000000, 8'h00, 8'h00);
        go_to(7, 7);
        tick();
        go_to(5, 4);
        do_load(32'h55555555, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        chk("async_rst_an", an, 8'hFF);
        chk("async_rst_seg", seg, 8'hFF);
        tick();
        rst = 1'b0;
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_idx", dut.idx, 0);
        chk("rst_pend", dut.pend_valid, 0);
        clear_seen();
        run(140);
        chk("post_rst_d0", seen_seg[0], 8'hC0);
        chk("post_rst_d5", seen_seg[5], 8'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
